// File: rtl/sim_io_port_pkg.sv
// Shared constants and types for the memory-mapped console port.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sim_io_port_pkg;

  // Register offsets within the 32-byte console window
  localparam logic [4:0] IO_CHAR_OFS = 5'h00;
  localparam logic [4:0] IO_WORD_OFS = 5'h04;
  localparam logic [4:0] IO_HALT_OFS = 5'h08;
  localparam logic [4:0] IO_STAT_OFS = 5'h0C;
  localparam logic [4:0] IO_CCNT_OFS = 5'h10;

  // Status register bit positions
  localparam int STAT_OVF_BIT    = 31;
  localparam int STAT_HALTED_BIT = 30;
  localparam int STAT_HEX_BIT    = 29;
  localparam int STAT_TX_BIT     = 28;
  localparam int STAT_FULL_BIT   = 17;
  localparam int STAT_EMPTY_BIT  = 16;

  typedef enum logic {
    HEX_IDLE = 1'b0,
    HEX_EMIT = 1'b1
  } hex_state_t;

  typedef enum logic [1:0] {
    U_IDLE  = 2'd0,
    U_START = 2'd1,
    U_DATA  = 2'd2,
    U_STOP  = 2'd3
  } uart_state_t;

  // Lowercase ASCII for one hex nibble: '0'..'9' then 'a'..'f' ('a' - 10 = 0x57)
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    hex_ascii = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h57 + {4'h0, nib});
  endfunction

endpackage

// File: rtl/sim_io_port_uart_tx.sv
// 8N1 UART transmitter: start bit, 8 data bits LSB first, one stop bit.
// Latency: byte accepted in idle, start bit begins next cycle; each bit lasts CLKS_PER_BIT cycles.
// Backpressure: ready only in idle, so a new byte is taken one cycle after the stop bit ends.
module uart_tx_8n1
  import sim_io_port_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  uart_state_t   state;
  uart_state_t   state_nxt;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          bit_end;

  assign bit_end = (baud_cnt == CW'(CLKS_PER_BIT - 1));
  assign ready   = (state == U_IDLE);
  assign busy    = (state != U_IDLE);

  // State register; reset drops any frame in flight so the line goes idle at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= U_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and line drive; each non-idle state lasts one full bit time
  always_comb begin
    state_nxt = state;
    tx        = 1'b1;
    case (state)
      U_IDLE: begin
        if (valid) state_nxt = U_START;
      end
      U_START: begin
        tx = 1'b0;
        if (bit_end) state_nxt = U_DATA;
      end
      U_DATA: begin
        tx = shreg[0];
        if (bit_end && (bit_idx == 3'd7)) state_nxt = U_STOP;
      end
      U_STOP: begin
        if (bit_end) state_nxt = U_IDLE;
      end
      default: state_nxt = U_IDLE;
    endcase
  end

  // Bit timer, data bit index and shift register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      shreg    <= 8'h00;
    end else begin
      if ((state == U_IDLE) || bit_end) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end

      if (state == U_START) begin
        bit_idx <= 3'd0;
      end else if ((state == U_DATA) && bit_end) begin
        bit_idx <= bit_idx + 3'd1;
      end

      if ((state == U_IDLE) && valid) begin
        shreg <= data;
      end else if ((state == U_DATA) && bit_end) begin
        shreg <= {1'b0, shreg[7:1]};
      end
    end
  end

endmodule

// File: rtl/sim_io_port.sv
// Memory-mapped console: char/hex-word output through a FIFO and 8N1 UART, status, cycle counter, halt.
// Latency: loads return registered data the cycle after dmem_re; a stored char starts its frame 2 cycles later.
// Backpressure: none toward the core; writes hitting a full FIFO or busy hex engine are dropped and flag overflow.
module sim_io_port
  import sim_io_port_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0,
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_AW      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dmem_we,
  input  logic        dmem_re,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  output logic        io_sel,
  output logic [31:0] dmem_rdata,
  output logic        uart_tx,
  output logic        halt,
  output logic [31:0] cycle_count
);

  localparam int DEPTH = 1 << FIFO_AW;

  // Address decode
  logic [4:0] ofs;
  logic       wr_sel;
  logic       rd_sel;
  logic       wr_char;
  logic       wr_word;
  logic       wr_halt;
  logic       wr_stat;

  assign io_sel  = (dmem_addr[31:5] == BASE_ADDR[31:5]);
  assign ofs     = dmem_addr[4:0];
  assign wr_sel  = dmem_we && io_sel;
  assign rd_sel  = dmem_re && io_sel;
  assign wr_char = wr_sel && (ofs == IO_CHAR_OFS);
  assign wr_word = wr_sel && (ofs == IO_WORD_OFS);
  assign wr_halt = wr_sel && (ofs == IO_HALT_OFS);
  assign wr_stat = wr_sel && (ofs == IO_STAT_OFS);

  // Character FIFO; pointers carry an extra wrap bit so full and empty differ
  logic [7:0]       fifo_mem [DEPTH];
  logic [FIFO_AW:0] wr_ptr;
  logic [FIFO_AW:0] rd_ptr;
  logic [FIFO_AW:0] fifo_cnt;
  logic             fifo_empty;
  logic             fifo_full;
  logic             fifo_pop;
  logic [7:0]       fifo_rd_dat;
  logic             push_vld;
  logic [7:0]       push_dat;

  // UART side
  logic uart_ready;
  logic tx_busy;

  // Hex engine
  hex_state_t  hex_state;
  hex_state_t  hex_state_nxt;
  logic [31:0] hexreg;
  logic [2:0]  hex_idx;
  logic        hex_busy;
  logic        hex_push;

  // Sticky flags and status
  logic        overflow;
  logic        halted;
  logic [31:0] status;

  assign fifo_cnt    = wr_ptr - rd_ptr;
  assign fifo_empty  = (fifo_cnt == '0);
  assign fifo_pop    = !fifo_empty && uart_ready;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept a push
  assign fifo_full   = (fifo_cnt == (FIFO_AW + 1)'(DEPTH)) && !fifo_pop;
  assign fifo_rd_dat = fifo_mem[rd_ptr[FIFO_AW-1:0]];
  assign hex_busy    = (hex_state == HEX_EMIT);

  // Push-port arbitration: a char store wins, the hex engine stalls that cycle
  always_comb begin
    push_vld = 1'b0;
    push_dat = 8'h00;
    hex_push = 1'b0;
    if (wr_char) begin
      if (!fifo_full) begin
        push_vld = 1'b1;
        push_dat = dmem_wdata[7:0];
      end
    end else if (hex_busy && !fifo_full) begin
      push_vld = 1'b1;
      push_dat = hex_ascii(hexreg[31:28]);
      hex_push = 1'b1;
    end
  end

  // FIFO pointers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_vld) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // FIFO storage; contents are don't-care while the pointers say empty
  always_ff @(posedge clk) begin
    if (push_vld) fifo_mem[wr_ptr[FIFO_AW-1:0]] <= push_dat;
  end

  // Hex engine state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hex_state <= HEX_IDLE;
    end else begin
      hex_state <= hex_state_nxt;
    end
  end

  // Hex engine next state: leave EMIT once the eighth digit is pushed
  always_comb begin
    hex_state_nxt = hex_state;
    case (hex_state)
      HEX_IDLE: if (wr_word) hex_state_nxt = HEX_EMIT;
      HEX_EMIT: if (hex_push && (hex_idx == 3'd7)) hex_state_nxt = HEX_IDLE;
      default:  hex_state_nxt = HEX_IDLE;
    endcase
  end

  // Hex word register shifts left so the next digit is always the top nibble
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hexreg  <= 32'h0;
      hex_idx <= 3'd0;
    end else if (!hex_busy && wr_word) begin
      hexreg  <= dmem_wdata;
      hex_idx <= 3'd0;
    end else if (hex_push) begin
      hexreg  <= {hexreg[27:0], 4'h0};
      hex_idx <= hex_idx + 3'd1;
    end
  end

  // Overflow records any dropped byte or word; cleared by writing bit 31 of status
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if ((wr_char && fifo_full) || (wr_word && hex_busy)) begin
      overflow <= 1'b1;
    end else if (wr_stat && dmem_wdata[31]) begin
      overflow <= 1'b0;
    end
  end

  // Halt request is sticky until reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      halted <= 1'b0;
    end else if (wr_halt) begin
      halted <= 1'b1;
    end
  end

  // Cycle counter freezes from the cycle after the halt store
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_count <= 32'h0;
    end else if (!halted) begin
      cycle_count <= cycle_count + 32'd1;
    end
  end

  // halt only once every queued character has left the serial line
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      halt <= 1'b0;
    end else begin
      halt <= halted && fifo_empty && !hex_busy && !tx_busy;
    end
  end

  // Status word assembly
  always_comb begin
    status                  = 32'h0;
    status[STAT_OVF_BIT]    = overflow;
    status[STAT_HALTED_BIT] = halted;
    status[STAT_HEX_BIT]    = hex_busy;
    status[STAT_TX_BIT]     = tx_busy;
    status[STAT_FULL_BIT]   = fifo_full;
    status[STAT_EMPTY_BIT]  = fifo_empty;
    status[FIFO_AW:0]       = fifo_cnt;
  end

  // Registered load data; zero whenever the window is not being read
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dmem_rdata <= 32'h0;
    end else if (rd_sel) begin
      case (ofs)
        IO_STAT_OFS: dmem_rdata <= status;
        IO_CCNT_OFS: dmem_rdata <= cycle_count;
        default:     dmem_rdata <= 32'h0;
      endcase
    end else begin
      dmem_rdata <= 32'h0;
    end
  end

  uart_tx_8n1 #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk   (clk),
    .reset (reset),
    .valid (!fifo_empty),
    .data  (fifo_rd_dat),
    .ready (uart_ready),
    .tx    (uart_tx),
    .busy  (tx_busy)
  );

endmodule

// File: tb/tb_sim_io_port.sv
// Scoreboard bench for sim_io_port: expected UART bytes and load data are queued at stimulus time
// and checked by independent line and load-data monitors.
module tb_sim_io_port;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int          CPB  = 4;
  localparam int          AW   = 4;
  localparam logic [31:0] ALL  = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [31:0] addr = BASE;
  logic [31:0] wdata = 32'h0;
  logic        io_sel;
  logic [31:0] rdata;
  logic        uart_tx;
  logic        halt;
  logic [31:0] ccnt;

  sim_io_port #(
    .BASE_ADDR   (BASE),
    .CLKS_PER_BIT(CPB),
    .FIFO_AW     (AW)
  ) dut (
    .clk        (clk),
    .reset      (rst),
    .dmem_we    (we),
    .dmem_re    (re),
    .dmem_addr  (addr),
    .dmem_wdata (wdata),
    .io_sel     (io_sel),
    .dmem_rdata (rdata),
    .uart_tx    (uart_tx),
    .halt       (halt),
    .cycle_count(ccnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] lo;
    logic [31:0] hi;
    logic [31:0] mask;
  } rd_exp_t;

  logic [7:0] exp_q[$];
  logic [7:0] hex_pend[$];
  rd_exp_t    rd_q[$];
  logic       char_ok = 1'b1;
  logic [31:0] m_cnt;
  logic        m_halted;
  int          cyc = 0;
  int          last_end = 0;
  logic        rd_flag = 1'b0;

  function automatic logic [7:0] ascii(input logic [3:0] n);
    if (n < 10) return 8'd48 + 8'(n);
    return 8'd97 + 8'(n) - 8'd10;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference cycle counter: counts every cycle out of reset, frozen after the halt store
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt    <= 32'h0;
      m_halted <= 1'b0;
    end else begin
      if (!m_halted) m_cnt <= m_cnt + 32'd1;
      if (we && addr == BASE + 32'h8) m_halted <= 1'b1;
    end
  end

  // Reference byte stream: a char store takes the slot, else one pending hex digit per cycle
  always @(posedge clk) begin : byte_model
    logic busy;
    if (!rst) begin
      busy = (hex_pend.size() != 0);
      if (we && addr == BASE) begin
        if (char_ok) exp_q.push_back(wdata[7:0]);
      end else if (busy) begin
        exp_q.push_back(hex_pend.pop_front());
      end
      if (we && addr == BASE + 32'h4 && !busy)
        for (int i = 0; i < 8; i++) hex_pend.push_back(ascii(wdata[31-4*i -: 4]));
    end
  end

  // Load-data monitor
  always @(posedge clk) rd_flag <= re;
  always @(negedge clk) begin : rd_mon
    rd_exp_t e;
    logic [31:0] act;
    if (rd_flag) begin
      total++;
      if (rd_q.size() == 0) begin
        bad++;
        $display("FAIL rd_unexpected: got %h want no load", rdata);
      end else begin
        e   = rd_q.pop_front();
        act = rdata & e.mask;
        if (act < e.lo || act > e.hi) begin
          bad++;
          $display("FAIL rdata: got %h (mask %h) want %h..%h", act, e.mask, e.lo, e.hi);
        end
      end
    end
  end

  // Serial line monitor: 40 cycle samples per frame, every bit must hold CPB cycles
  initial begin : uart_mon
    logic [39:0] got;
    logic [39:0] want;
    logic [7:0]  e;
    logic        abort;
    forever begin
      @(negedge clk);
      if (!rst && uart_tx === 1'b0) begin
        abort  = 1'b0;
        got[0] = uart_tx;
        for (int k = 1; k < 40; k++) begin
          @(negedge clk);
          if (rst) abort = 1'b1;
          got[k] = uart_tx;
        end
        if (!abort) begin
          last_end = cyc;
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL uart_unexpected: got frame %h want none", got);
          end else begin
            e = exp_q.pop_front();
            for (int k = 0; k < 4; k++) want[k] = 1'b0;
            for (int b = 0; b < 8; b++)
              for (int j = 0; j < 4; j++) want[4+4*b+j] = e[b];
            for (int k = 36; k < 40; k++) want[k] = 1'b1;
            if (got !== want) begin
              bad++;
              $display("FAIL uart_frame: got %h want %h (byte %h)", got, want, e);
            end
          end
        end
      end
    end
  end

  task automatic bus(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] lo, input logic [31:0] hi, input logic [31:0] mask,
                     input logic use_cnt);
    rd_exp_t e;
    @(negedge clk);
    we = w; re = r; addr = a; wdata = d;
    @(posedge clk);
    if (r) begin
      e.lo   = use_cnt ? m_cnt : lo;
      e.hi   = use_cnt ? m_cnt : hi;
      e.mask = mask;
      rd_q.push_back(e);
    end
    #1;
    we = 1'b0; re = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus(1'b1, 1'b0, a, d, 32'h0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] v, input logic [31:0] mask);
    bus(1'b0, 1'b1, a, 32'h0, v, v, mask, 1'b0);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || hex_pend.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= budget) begin
      bad++;
      $display("FAIL drain: got %0d bytes outstanding want 0", exp_q.size() + hex_pend.size());
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin : main
    int n;
    int rise;
    int nc;
    int nw;

    // Reset state
    #2;
    chk("rst_tx", {31'b0, uart_tx}, 32'h1);
    chk("rst_halt", {31'b0, halt}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_ccnt", ccnt, 32'h0);
    #1 chk("io_sel_hit", {31'b0, io_sel}, 32'h1);
    addr = BASE + 32'h20;
    #1 chk("io_sel_miss", {31'b0, io_sel}, 32'h0);
    addr = BASE;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 1: single 'A' frame, busy during, idle status after
    wr(BASE, 32'h41);
    repeat (10) @(negedge clk);
    rd(BASE + 32'hC, 32'h1000_0000, 32'h1000_0000);
    wait_drain(200);
    rd(BASE + 32'hC, 32'h0001_0000, ALL);
    bus(1'b0, 1'b1, BASE + 32'h10, 32'h0, 32'h0, 32'h0, ALL, 1'b1);
    rd(BASE + 32'h14, 32'h0, ALL);
    rd(BASE + 32'h2C, 32'h0, ALL);

    // 2: hex word, second word while busy overflows
    wr(BASE + 32'h4, 32'hDEAD_BEEF);
    wr(BASE + 32'h4, 32'h1234_5678);
    rd(BASE + 32'hC, 32'hA000_0000, 32'hA000_0000);
    wait_drain(8 * 41 + 100);
    wr(BASE + 32'hC, 32'h8000_0000);
    rd(BASE + 32'hC, 32'h0, 32'h8000_0000);

    // 3: 20 back-to-back chars into a 16-deep FIFO: first 17 survive
    for (int i = 0; i < 20; i++) begin
      char_ok = (i < 17);
      wr(BASE, 32'h30 + i);
    end
    char_ok = 1'b1;
    rd(BASE + 32'hC, 32'h8002_0000, 32'h8002_0000);
    wr(BASE + 32'hC, 32'h7FFF_FFFF);
    rd(BASE + 32'hC, 32'h8000_0000, 32'h8000_0000);
    wr(BASE + 32'hC, 32'h8000_0000);
    rd(BASE + 32'hC, 32'h0, 32'h8000_0000);
    wait_drain(17 * 41 + 100);

    // 4: char store collides with hex digit pushes
    wr(BASE + 32'h4, 32'h0123_4567);
    @(negedge clk);
    wr(BASE, 32'h5A);
    wait_drain(9 * 41 + 100);

    // Randomized bursts of words, chars and ignored accesses
    for (int it = 0; it < 10; it++) begin
      nw = $urandom_range(0, 1);
      nc = $urandom_range(0, 3);
      for (int s = 0; s < nw + nc; s++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        if (s == 0 && nw == 1) wr(BASE + 32'h4, $urandom);
        else wr(BASE, 32'($urandom_range(0, 255)));
      end
      wr(BASE + 32'h20, $urandom);
      wr(BASE + 32'h18, $urandom);
      rd(BASE + 32'h14, 32'h0, ALL);
      bus(1'b0, 1'b1, BASE + 32'h10, 32'h0, 32'h0, 32'h0, ALL, 1'b1);
      wait_drain(11 * 41 + 100);
    end

    // 5: halt at cycle 100 with bytes queued
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    hex_pend.delete();
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (m_cnt != 96 && n < 200) begin
      @(negedge clk);
      n++;
    end
    wr(BASE, 32'h61);
    wr(BASE, 32'h62);
    wr(BASE, 32'h63);
    wr(BASE + 32'h8, 32'h0);
    rd(BASE + 32'h10, 32'd100, ALL);
    rd_q[rd_q.size()-1].hi = 32'd101;
    repeat (20) @(negedge clk);
    rd(BASE + 32'h10, 32'd100, ALL);
    rd_q[rd_q.size()-1].hi = 32'd101;
    n = 0;
    while (!halt && n < 400) begin
      @(negedge clk);
      n++;
    end
    rise = cyc;
    chk("halt_rise", {31'b0, halt}, 32'h1);
    chk("halt_delay", 32'(rise - last_end), 32'd2);
    chk("queue_after_halt", 32'(exp_q.size()), 32'd0);

    // 6: reset in the middle of a data bit
    wr(BASE, 32'h00);
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    exp_q.delete();
    hex_pend.delete();
    #1;
    chk("mid_rst_tx", {31'b0, uart_tx}, 32'h1);
    chk("mid_rst_halt", {31'b0, halt}, 32'h0);
    chk("mid_rst_ccnt", ccnt, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    rd(BASE + 32'hC, 32'h0001_0000, ALL);
    repeat (60) @(negedge clk);
    chk("rd_leftover", 32'(rd_q.size()), 32'd0);
    chk("uart_leftover", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
